// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback
// and drives every datapath enable and mux select. The shared memory is
// accessed through a request/ready handshake.
//
// Ports:
//   clk_i, rst_i                - clock, synchronous active-high reset
//   instr_op_i, funct_i         - IR opcode and funct fields
//   zero_i, sign_i              - ALU result flags for branch resolution
//   mem_ready_i                 - memory completes the current request
//   mem_req_o, mem_we_o, iord_o - memory request, write, address select
//   ir_we_o, pc_we_o, pc_src_o  - IR/MDR load, PC write and PC source
//   reg_we_o, reg_dst_o, mem_to_reg_o - register file write controls
//   alu_src_a_o, alu_src_b_o, alu_op_o - ALU operand and op selects
//   state_o                     - current state (debug)
//   illegal_o                   - unsupported opcode trapped
//   cycle_cnt_o, instr_cnt_o    - performance counters (PERF_CNT_EN only)
//
// Optional feature macro: PERF_CNT_EN
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       sign_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_we_o,
   output logic       iord_o,
   output logic       ir_we_o,
   output logic       pc_we_o,
   output logic [1:0] pc_src_o,
   output logic       reg_we_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [2:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [3:0] state_o,
   output logic       illegal_o
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instr_cnt_o
`endif
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      EXEC_I   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      JAL      = 4'd12,
      JR       = 4'd13,
      TRAP     = 4'd14
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BGEZ  = 6'h01;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   state_e state_q, state_d;

   // ALU op for the I-type group; shared by EXEC_I and I_WB so I_WB holds it
   logic [2:0] i_alu_op;
   logic [2:0] i_alu_src_b;
   always_comb begin
      i_alu_op    = 3'b000;
      i_alu_src_b = 3'b010;
      case (instr_op_i)
         OP_SLTI: i_alu_op = 3'b011;
         OP_ORI:  begin i_alu_op = 3'b100; i_alu_src_b = 3'b101; end
         OP_LUI:  begin i_alu_op = 3'b101; i_alu_src_b = 3'b101; end
         default: ;
      endcase
   end

   // Next-state and output decode; reset gates every output to zero
   always_comb begin
      state_d      = state_q;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_src_o     = 2'b00;
      reg_we_o     = 1'b0;
      reg_dst_o    = 2'b00;
      mem_to_reg_o = 2'b00;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 3'b000;
      alu_op_o     = 3'b000;
      illegal_o    = 1'b0;

      case (state_q)
         FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = 3'b001;
            if (mem_ready_i) begin
               ir_we_o = 1'b1;
               pc_we_o = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            alu_src_b_o = 3'b011;
            case (instr_op_i)
               OP_RTYPE: state_d = (funct_i == FN_JR) ? JR : EXEC_R;
               OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_d = EXEC_I;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BGT, OP_BGEZ: state_d = BRANCH;
               OP_J:   state_d = JUMP;
               OP_JAL: state_d = JAL;
               default: state_d = TRAP;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 3'b010;
            state_d     = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req_o = 1'b1;
            iord_o    = 1'b1;
            if (mem_ready_i) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_we_o     = 1'b1;
            mem_to_reg_o = 2'b01;
            state_d      = FETCH;
         end
         MEM_WR: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            iord_o    = 1'b1;
            if (mem_ready_i) state_d = FETCH;
         end
         EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
            state_d     = R_WB;
         end
         R_WB: begin
            reg_we_o  = 1'b1;
            reg_dst_o = 2'b01;
            state_d   = FETCH;
         end
         EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = i_alu_src_b;
            alu_op_o    = i_alu_op;
            state_d     = I_WB;
         end
         I_WB: begin
            reg_we_o = 1'b1;
            alu_op_o = i_alu_op;
            state_d  = FETCH;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b001;
            pc_src_o    = 2'b01;
            case (instr_op_i)
               OP_BEQ:  pc_we_o = zero_i;
               OP_BNE:  pc_we_o = ~zero_i;
               OP_BGT:  pc_we_o = ~zero_i & ~sign_i;
               OP_BGEZ: begin
                  alu_src_b_o = 3'b100;
                  pc_we_o     = ~sign_i;
               end
               default: ;
            endcase
            state_d = FETCH;
         end
         JUMP: begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b10;
            state_d  = FETCH;
         end
         JAL: begin
            pc_we_o      = 1'b1;
            pc_src_o     = 2'b10;
            reg_we_o     = 1'b1;
            reg_dst_o    = 2'b10;
            mem_to_reg_o = 2'b11;
            state_d      = FETCH;
         end
         JR: begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b11;
            state_d  = FETCH;
         end
         TRAP: begin
            illegal_o = 1'b1;
         end
         default: state_d = FETCH;
      endcase

      if (rst_i) begin
         mem_req_o    = 1'b0;
         mem_we_o     = 1'b0;
         iord_o       = 1'b0;
         ir_we_o      = 1'b0;
         pc_we_o      = 1'b0;
         pc_src_o     = 2'b00;
         reg_we_o     = 1'b0;
         reg_dst_o    = 2'b00;
         mem_to_reg_o = 2'b00;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 3'b000;
         alu_op_o     = 3'b000;
         illegal_o    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FETCH;
      else       state_q <= state_d;
   end

   assign state_o = state_q;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   // Cycle count freezes in TRAP; instruction count ticks on re-entry to FETCH
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (state_q != TRAP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if ((state_d == FETCH) && (state_q != FETCH))
         instr_cnt_d = instr_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
